// File: rtl/fifo_pkt_drain.sv
// Drains an upstream sync FIFO into fixed-length packets with sop/eop framing and a forced idle gap.
// Optional m_parity output is enabled by defining FIFO_DRAIN_PARITY_EN.
module fifo_pkt_drain #(
    parameter int B       = 8,
    parameter int PKT_LEN = 4,
    parameter int GAP     = 2
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         fifo_empty,
    input  logic [B-1:0] fifo_r_data,
    output logic         fifo_rd,
    output logic [B-1:0] m_data,
    output logic         m_valid,
    input  logic         m_ready,
    output logic         m_sop,
    output logic         m_eop,
    output logic [15:0]  pkt_cnt,
    output logic         busy
`ifdef FIFO_DRAIN_PARITY_EN
    ,
    output logic         m_parity
`endif
);

    localparam int LW = $clog2(PKT_LEN + 1);
    localparam int GW = (GAP > 1) ? $clog2(GAP) : 1;

    typedef enum logic [1:0] {
        IDLE,
        STREAM,
        GAP_WAIT
    } state_t;

    state_t        state_q, state_d;
    logic [LW-1:0] loaded_q, loaded_d;
    logic [GW-1:0] gap_cnt_q, gap_cnt_d;
    logic [B-1:0]  m_data_q, m_data_d;
    logic          m_valid_q, m_valid_d;
    logic          m_sop_q, m_sop_d;
    logic          m_eop_q, m_eop_d;
    logic [15:0]   pkt_cnt_q, pkt_cnt_d;
`ifdef FIFO_DRAIN_PARITY_EN
    logic          parity_q, parity_d;
`endif

    logic pop;
    logic accept;

    always_comb begin
        // Reset gates the pop so an X state before the first edge cannot strobe the FIFO.
        pop = !reset && !fifo_empty && (!m_valid_q || m_ready)
              && (loaded_q < LW'(PKT_LEN)) && (state_q != GAP_WAIT);
        accept = m_valid_q && m_ready;

        state_d   = state_q;
        loaded_d  = loaded_q;
        gap_cnt_d = gap_cnt_q;
        m_data_d  = m_data_q;
        m_valid_d = m_valid_q;
        m_sop_d   = m_sop_q;
        m_eop_d   = m_eop_q;
        pkt_cnt_d = pkt_cnt_q;
`ifdef FIFO_DRAIN_PARITY_EN
        parity_d  = parity_q;
`endif

        if (accept) begin
            m_valid_d = 1'b0;
        end

        if (pop) begin
            m_data_d  = fifo_r_data;
            m_valid_d = 1'b1;
            m_sop_d   = (loaded_q == '0);
            m_eop_d   = (loaded_q == LW'(PKT_LEN - 1));
            loaded_d  = loaded_q + LW'(1);
`ifdef FIFO_DRAIN_PARITY_EN
            parity_d  = ^fifo_r_data;
`endif
        end

        case (state_q)
            IDLE: begin
                if (pop) begin
                    state_d = STREAM;
                end
            end
            STREAM: begin
                // The eop word can only be pending once loaded has reached PKT_LEN, so no pop collides here.
                if (accept && m_eop_q) begin
                    pkt_cnt_d = pkt_cnt_q + 16'd1;
                    loaded_d  = '0;
                    gap_cnt_d = '0;
                    state_d   = (GAP > 0) ? GAP_WAIT : IDLE;
                end
            end
            GAP_WAIT: begin
                if (gap_cnt_q == GW'(GAP - 1)) begin
                    state_d = IDLE;
                end else begin
                    gap_cnt_d = gap_cnt_q + GW'(1);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            loaded_q  <= '0;
            gap_cnt_q <= '0;
            m_data_q  <= '0;
            m_valid_q <= 1'b0;
            m_sop_q   <= 1'b0;
            m_eop_q   <= 1'b0;
            pkt_cnt_q <= '0;
`ifdef FIFO_DRAIN_PARITY_EN
            parity_q  <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            loaded_q  <= loaded_d;
            gap_cnt_q <= gap_cnt_d;
            m_data_q  <= m_data_d;
            m_valid_q <= m_valid_d;
            m_sop_q   <= m_sop_d;
            m_eop_q   <= m_eop_d;
            pkt_cnt_q <= pkt_cnt_d;
`ifdef FIFO_DRAIN_PARITY_EN
            parity_q  <= parity_d;
`endif
        end
    end

    assign fifo_rd  = pop;
    assign m_data   = m_data_q;
    assign m_valid  = m_valid_q;
    assign m_sop    = m_sop_q;
    assign m_eop    = m_eop_q;
    assign pkt_cnt  = pkt_cnt_q;
    assign busy     = (state_q != IDLE);
`ifdef FIFO_DRAIN_PARITY_EN
    assign m_parity = parity_q;
`endif

endmodule

// File: tb/tb_fifo_pkt_drain.sv
// Scoreboard bench for fifo_pkt_drain: unit 0 uses PKT_LEN=4/GAP=2, unit 1 uses PKT_LEN=1/GAP=0.
module tb_fifo_pkt_drain;

    typedef struct packed {
        logic [7:0] d;
        logic       s;
        logic       e;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst     [2];
    logic        m_ready [2];
    logic        empty   [2];
    logic        rd      [2];
    logic        mv      [2];
    logic        sop     [2];
    logic        eop     [2];
    logic        busy    [2];
    logic [7:0]  rdata   [2];
    logic [7:0]  mdata   [2];
    logic [15:0] pcnt    [2];
`ifdef FIFO_DRAIN_PARITY_EN
    logic        par     [2];
`endif

    logic [7:0] mem [2][64];
    int wr  [2];
    int pos [2];
    int rp  [2] = '{0, 0};

    exp_t sb[$];
    int n_checks = 0;
    int n_fail   = 0;

    assign empty[0] = (rp[0] == wr[0]);
    assign empty[1] = (rp[1] == wr[1]);
    assign rdata[0] = mem[0][rp[0][5:0]];
    assign rdata[1] = mem[1][rp[1][5:0]];

    always @(posedge clk) begin
        if (rd[0]) rp[0] <= rp[0] + 1;
        if (rd[1]) rp[1] <= rp[1] + 1;
    end

    fifo_pkt_drain #(.B(8), .PKT_LEN(4), .GAP(2)) u_dut0 (
        .clk(clk), .reset(rst[0]), .fifo_empty(empty[0]), .fifo_r_data(rdata[0]),
        .fifo_rd(rd[0]), .m_data(mdata[0]), .m_valid(mv[0]), .m_ready(m_ready[0]),
        .m_sop(sop[0]), .m_eop(eop[0]), .pkt_cnt(pcnt[0]), .busy(busy[0])
`ifdef FIFO_DRAIN_PARITY_EN
        , .m_parity(par[0])
`endif
    );

    fifo_pkt_drain #(.B(8), .PKT_LEN(1), .GAP(0)) u_dut1 (
        .clk(clk), .reset(rst[1]), .fifo_empty(empty[1]), .fifo_r_data(rdata[1]),
        .fifo_rd(rd[1]), .m_data(mdata[1]), .m_valid(mv[1]), .m_ready(m_ready[1]),
        .m_sop(sop[1]), .m_eop(eop[1]), .pkt_cnt(pcnt[1]), .busy(busy[1])
`ifdef FIFO_DRAIN_PARITY_EN
        , .m_parity(par[1])
`endif
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic push(input int u, input logic [7:0] d);
        exp_t x;
        int plen;
        plen = (u == 0) ? 4 : 1;
        mem[u][wr[u][5:0]] = d;
        x.d = d;
        x.s = (pos[u] == 0);
        x.e = (pos[u] == plen - 1);
        sb.push_back(x);
        pos[u] = (pos[u] + 1) % plen;
        wr[u]++;
    endtask

    // One clock of unit u: protocol checks and scoreboard compare on the negedge, return #1 after posedge.
    task automatic tick(input int u);
        exp_t x;
        @(negedge clk);
        if (rst[u]) chk("rd_in_reset", 32'(rd[u]), 32'd0);
        else if (rd[u] === 1'b1) chk("rd_when_empty", 32'(empty[u]), 32'd0);
        if (mv[u] === 1'b1 && m_ready[u]) begin
            chk("beat_expected", (sb.size() > 0) ? 32'd1 : 32'd0, 32'd1);
            if (sb.size() > 0) begin
                x = sb.pop_front();
                chk("beat_data", 32'(mdata[u]), 32'(x.d));
                chk("beat_sop", 32'(sop[u]), 32'(x.s));
                chk("beat_eop", 32'(eop[u]), 32'(x.e));
`ifdef FIFO_DRAIN_PARITY_EN
                chk("beat_parity", 32'(par[u]), 32'(^x.d));
`endif
            end
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst[0] = 1'b1; rst[1] = 1'b1;
        m_ready[0] = 1'b1; m_ready[1] = 1'b1;
        wr[0] = 0; wr[1] = 0; pos[0] = 0; pos[1] = 0;

        tick(0);
        tick(0);
        chk("rst_valid", 32'(mv[0]), 32'd0);
        chk("rst_pkt_cnt", 32'(pcnt[0]), 32'd0);
        chk("rst_busy", 32'(busy[0]), 32'd0);
        chk("rst_data", 32'(mdata[0]), 32'd0);
        chk("rst_sop_eop", {30'd0, sop[0], eop[0]}, 32'd0);
        chk("rst_valid_u1", 32'(mv[1]), 32'd0);

        // Basic packet, preloaded while still in reset.
        push(0, 8'h11); push(0, 8'h22); push(0, 8'h33); push(0, 8'h44);
        tick(0);
        chk("rst_hold_valid", 32'(mv[0]), 32'd0);
        rst[0] = 1'b0; rst[1] = 1'b0;
        tick(0);
        for (int i = 0; i < 4; i++) begin
            chk("a_consecutive_valid", 32'(mv[0]), 32'd1);
            if (i == 3) begin
                push(0, 8'h11); push(0, 8'h22); push(0, 8'h33); push(0, 8'h44);
            end
            tick(0);
        end
        chk("a_pkt_cnt", 32'(pcnt[0]), 32'd1);
        chk("a_gap1_valid", 32'(mv[0]), 32'd0);
        chk("a_gap1_rd", 32'(rd[0]), 32'd0);
        chk("a_gap1_busy", 32'(busy[0]), 32'd1);
        tick(0);
        chk("a_gap2_valid", 32'(mv[0]), 32'd0);
        chk("a_gap2_rd", 32'(rd[0]), 32'd0);
        tick(0);
        chk("a_idle_busy", 32'(busy[0]), 32'd0);
        chk("a_idle_rd", 32'(rd[0]), 32'd1);

        // Backpressure on the second beat.
        tick(0);
        chk("b_first_data", 32'(mdata[0]), 32'h11);
        tick(0);
        chk("b_second_data", 32'(mdata[0]), 32'h22);
        m_ready[0] = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick(0);
            chk("b_hold_data", 32'(mdata[0]), 32'h22);
            chk("b_hold_valid", 32'(mv[0]), 32'd1);
            chk("b_hold_sop", 32'(sop[0]), 32'd0);
            chk("b_hold_rd", 32'(rd[0]), 32'd0);
        end
        m_ready[0] = 1'b1;
        tick(0); tick(0); tick(0);
        chk("b_pkt_cnt", 32'(pcnt[0]), 32'd2);
        chk("b_sb_empty", 32'(sb.size()), 32'd0);
        tick(0); tick(0);
        chk("b_idle", 32'(busy[0]), 32'd0);

        // FIFO runs dry mid-packet, then refills.
        push(0, 8'h11); push(0, 8'h22);
        tick(0); tick(0); tick(0);
        chk("c_starved_valid", 32'(mv[0]), 32'd0);
        chk("c_starved_busy", 32'(busy[0]), 32'd1);
        tick(0); tick(0); tick(0);
        chk("c_wait_valid", 32'(mv[0]), 32'd0);
        chk("c_wait_busy", 32'(busy[0]), 32'd1);
        push(0, 8'h33); push(0, 8'h44);
        tick(0);
        chk("c_refill_data", 32'(mdata[0]), 32'h33);
        chk("c_refill_sop", 32'(sop[0]), 32'd0);
        tick(0); tick(0);
        chk("c_pkt_cnt", 32'(pcnt[0]), 32'd3);
        chk("c_sb_empty", 32'(sb.size()), 32'd0);
        tick(0); tick(0);

        // Reset mid-packet after two beats.
        push(0, 8'h11); push(0, 8'h22);
        tick(0); tick(0); tick(0);
        chk("d_two_beats", 32'(sb.size()), 32'd0);
        rst[0] = 1'b1;
        pos[0] = 0;
        push(0, 8'h5A);
        tick(0);
        chk("d_rst_valid", 32'(mv[0]), 32'd0);
        chk("d_rst_pkt_cnt", 32'(pcnt[0]), 32'd0);
        chk("d_rst_busy", 32'(busy[0]), 32'd0);
        rst[0] = 1'b0;
        tick(0);
        chk("d_new_valid", 32'(mv[0]), 32'd1);
        chk("d_new_sop", 32'(sop[0]), 32'd1);
        chk("d_new_data", 32'(mdata[0]), 32'h5A);
        push(0, 8'h6B); push(0, 8'h7C); push(0, 8'h8D);
        tick(0); tick(0); tick(0); tick(0);
        chk("d_pkt_cnt", 32'(pcnt[0]), 32'd1);
        chk("d_sb_empty", 32'(sb.size()), 32'd0);

        // Single-word packets with no gap.
        push(1, 8'hA1); push(1, 8'hA2); push(1, 8'hA3);
        for (int i = 0; i < 20 && sb.size() > 0; i++) tick(1);
        chk("e_sb_empty", 32'(sb.size()), 32'd0);
        chk("e_pkt_cnt", 32'(pcnt[1]), 32'd3);
        chk("e_idle", 32'(busy[1]), 32'd0);

`ifdef FIFO_DRAIN_PARITY_EN
        push(1, 8'h07); push(1, 8'h03);
        tick(1);
        chk("p_parity_07", 32'(par[1]), 32'd1);
        tick(1);
        tick(1);
        chk("p_parity_03", 32'(par[1]), 32'd0);
        tick(1);
        chk("p_sb_empty", 32'(sb.size()), 32'd0);
`endif

        $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
        $finish;
    end

endmodule

// File: doc/fifo_pkt_drain.md
FIFO_PKT_DRAIN -- requirements
Module: fifo_pkt_drain

Interface
REQ-001 SHALL have parameter B, default 8, meaning data word width in bits; legal range is B>=1.
REQ-002 SHALL have parameter PKT_LEN, default 4, meaning words per packet; legal range is PKT_LEN>=1.
REQ-003 SHALL have parameter GAP, default 2, meaning idle cycles forced between packets; legal range is GAP>=0.
REQ-004 SHALL have port clk, input, 1 bit: the single clock; all logic on rising edge.
REQ-005 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-006 SHALL have port fifo_empty, input, 1 bit: upstream sync FIFO empty flag.
REQ-007 SHALL have port fifo_r_data, input, B bits: upstream FIFO head word, valid while fifo_empty=0.
REQ-008 SHALL have port fifo_rd, output, 1 bit: pop strobe; the FIFO advances at the same rising edge.
REQ-009 SHALL have port m_data, output, B bits: registered output word.
REQ-010 SHALL have port m_valid, output, 1 bit: m_data holds a word.
REQ-011 SHALL have port m_ready, input, 1 bit: sink accepts the word when m_valid&m_ready at a rising edge.
REQ-012 SHALL have ports m_sop and m_eop, output, 1 bit each: first and last word of a packet, qualified by m_valid.
REQ-013 SHALL have port pkt_cnt, output, 16 bits: count of completed packets, wrapping from 0xFFFF to 0.
REQ-014 SHALL have port busy, output, 1 bit: asserted when the state is not IDLE.

Function
REQ-015 SHALL implement FSM states IDLE, STREAM and GAP_WAIT.
REQ-016 SHALL drive fifo_rd combinationally = ~fifo_empty & (~m_valid | m_ready) & (loaded<PKT_LEN) & state!=GAP_WAIT, where loaded = words of the current packet already popped (0 in IDLE).
REQ-017 SHALL, on each edge with fifo_rd=1, load m_data<=fifo_r_data, set m_valid, and increment loaded; latency is one cycle from fifo_empty=0 to m_valid=1.
REQ-018 SHALL, in IDLE, on a pop, set m_sop=1, set loaded=1 and move to STREAM; m_eop=1 on the same word iff PKT_LEN==1.
REQ-019 SHALL set m_eop=1 on the word that brings loaded to PKT_LEN, and m_sop=0 on all non-first words.
REQ-020 SHALL hold m_data, m_sop and m_eop stable and m_valid high while m_valid&~m_ready.
REQ-021 SHALL clear m_valid when a word is accepted and no pop occurs on the same edge; if the FIFO runs empty mid-packet, it SHALL wait in STREAM indefinitely with no timeout.
REQ-022 SHALL, when the m_eop word is accepted, increment pkt_cnt, reset loaded to 0, and go to GAP_WAIT if GAP>0, else to IDLE.
REQ-023 SHALL, in GAP_WAIT, keep fifo_rd=0 and m_valid=0 for exactly GAP cycles, then go to IDLE; IDLE may pop on the cycle it is entered.
REQ-024 SHALL never assert fifo_rd while fifo_empty=1.

Reset
REQ-025 SHALL, on a clock edge with reset=1, set state=IDLE, loaded=0, m_valid=0, m_sop=0, m_eop=0, m_data=0, pkt_cnt=0; a partial packet is discarded.
REQ-026 SHALL hold fifo_rd=0 while reset=1.

Configuration
REQ-027 SHALL, when FIFO_DRAIN_PARITY_EN is defined, add output m_parity (1 bit) = XOR of the word loaded into m_data, registered alongside it, held stable under backpressure (REQ-020), and reset to 0.
REQ-028 SHALL, when FIFO_DRAIN_PARITY_EN is undefined, omit the m_parity port entirely; all other behaviour is identical.

Verification
REQ-029 SHALL verify: with PKT_LEN=4, GAP=2, FIFO preloaded with 0x11..0x44 and m_ready=1 -> four consecutive beats, sop on 0x11, eop on 0x44, pkt_cnt=1, then 2 cycles of m_valid=0.
REQ-030 SHALL verify: m_ready=0 for 5 cycles on the second beat -> m_data=0x22 held, fifo_rd=0 throughout, no word lost or duplicated.
REQ-031 SHALL verify: FIFO empties after 2 words -> m_valid drops; a refill of 0x33,0x44 later completes the packet with eop on 0x44.
REQ-032 SHALL verify: PKT_LEN=1, GAP=0, 3 words -> each word has sop=eop=1, pkt_cnt=3.
REQ-033 SHALL verify: reset asserted mid-packet after 2 beats -> next cycle m_valid=0, pkt_cnt=0, and the next word carries sop=1.
REQ-034 SHALL verify: with FIFO_DRAIN_PARITY_EN defined, word 0x07 -> m_parity=1, and word 0x03 -> m_parity=0.
